// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency BRAM between NUM_PORTS requesters.
// Reads return one held response beat per port; writes complete at the grant edge.
module bram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               req_valid,
  output logic [NUM_PORTS-1:0]               req_ready,
  input  logic [NUM_PORTS-1:0]               req_write,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  req_strb,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_PORTS-1:0]               rsp_valid,
  input  logic [NUM_PORTS-1:0]               rsp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rsp_rdata,
  output logic                               bram_en,
  output logic [DATA_WIDTH/8-1:0]            bram_we,
  output logic [ADDR_WIDTH-1:0]              bram_addr,
  output logic [DATA_WIDTH-1:0]              bram_wrdata,
  input  logic [DATA_WIDTH-1:0]              bram_rddata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W-1:0]      rr_r;
  logic [NUM_PORTS-1:0]  rsp_valid_r;
  logic [NUM_PORTS-1:0]  fresh_r;
  logic [DATA_WIDTH-1:0] hold_r [NUM_PORTS];

  logic [NUM_PORTS-1:0]  eligible_s;
  logic [NUM_PORTS-1:0]  grant_s;
  logic                  gnt_any_s;
  logic [IDX_W-1:0]      gnt_idx_s;

  // (base + k) mod NUM_PORTS for base < NUM_PORTS and k <= NUM_PORTS
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_PORTS) begin
      sum = sum - NUM_PORTS;
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // A port may be granted if it writes, or if its response slot is empty or draining this cycle
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible_s[i] = req_valid[i] & (req_write[i] | ~rsp_valid_r[i] | rsp_ready[i]);
    end
  end

  // Work-conserving round-robin: first eligible port searching upward from rr+1
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             hit;
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    grant_s   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand      = wrap_add(rr_r, k);
      hit       = ~gnt_any_s & eligible_s[cand];
      gnt_idx_s = hit ? cand : gnt_idx_s;
      gnt_any_s = gnt_any_s | hit;
    end
    grant_s[gnt_idx_s] = gnt_any_s;
  end

  assign req_ready = grant_s;

  // Steer the granted request onto the BRAM port in the grant cycle
  always_comb begin
    bram_en     = gnt_any_s;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wrdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_s[i]) begin
        bram_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bram_wrdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        bram_we     = req_write[i] ? req_strb[i*STRB_W +: STRB_W] : {STRB_W{1'b0}};
      end else begin
        bram_addr   = bram_addr;
        bram_wrdata = bram_wrdata;
        bram_we     = bram_we;
      end
    end
  end

  // Round-robin pointer; starts at the last port so port 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_r <= IDX_W'(NUM_PORTS - 1);
    end else if (gnt_any_s) begin
      rr_r <= gnt_idx_s;
    end
  end

  // Response slots: fresh_r selects live BRAM data, otherwise the hold register drives the port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= '0;
      fresh_r     <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_s[i] & ~req_write[i]) begin
          rsp_valid_r[i] <= 1'b1;
          fresh_r[i]     <= 1'b1;
        end else if (rsp_valid_r[i] & rsp_ready[i]) begin
          rsp_valid_r[i] <= 1'b0;
          fresh_r[i]     <= 1'b0;
        end else if (rsp_valid_r[i] & fresh_r[i]) begin
          // Stalled first beat: BRAM output is only valid this cycle, so capture it
          hold_r[i]  <= bram_rddata;
          fresh_r[i] <= 1'b0;
        end
      end
    end
  end

  // Per-port read data mux
  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = fresh_r[i] ? bram_rddata : hold_r[i];
    end
  end

  assign rsp_valid = rsp_valid_r;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: directed vector table, reset-mid-read sequence, and random traffic
// compared every cycle against a transaction-level model with its own memory image.
module tb_bram_port_arbiter;

  localparam int NP = 2;
  localparam int DW = 64;
  localparam int AW = 8;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [NP*8-1:0]  req_strb;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata, rsp_rdata;
  logic             bram_en;
  logic [7:0]       bram_we;
  logic [AW-1:0]    bram_addr;
  logic [DW-1:0]    bram_wrdata, bram_rddata;

  int n_chk  = 0;
  int n_fail = 0;

  bram_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_strb(req_strb), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first BRAM with one cycle read latency
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 8; b++) begin
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] = bram_wrdata[b*8 +: 8];
      end
      bram_rddata <= mem[bram_addr];
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [256];
  int            rr_m = NP - 1;
  logic [NP-1:0] pend_m = '0;
  logic [DW-1:0] pdata_m [NP];
  int            g_q = -1;
  logic          reset_q = 1'b1;
  logic [NP-1:0] write_q, rrdy_q;
  logic [AW-1:0] addr_q [NP];
  logic [7:0]    strb_q [NP];
  logic [DW-1:0] wd_q [NP];

  always @(negedge clk) begin
    int g;
    int j;
    logic [NP-1:0] elig;
    logic [NP-1:0] exp_rdy;
    if (reset) begin
      pend_m = '0;
      rr_m   = NP - 1;
    end
    for (int i = 0; i < NP; i++)
      elig[i] = req_valid[i] & (req_write[i] | ~pend_m[i] | rsp_ready[i]);
    g = -1;
    for (int k = 1; k <= NP; k++) begin
      j = (rr_m + k) % NP;
      if (g < 0 && elig[j]) g = j;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("m_req_ready", req_ready, exp_rdy);
    chk("m_bram_en", bram_en, (g >= 0));
    if (g >= 0) begin
      chk("m_bram_addr", bram_addr, req_addr[g*AW +: AW]);
      chk("m_bram_we", bram_we, req_write[g] ? req_strb[g*8 +: 8] : 8'h00);
      if (req_write[g]) chk("m_bram_wrdata", bram_wrdata, req_wdata[g*DW +: DW]);
    end else begin
      chk("m_bram_we_idle", bram_we, 8'h00);
    end
    chk("m_rsp_valid", rsp_valid, pend_m);
    for (int i = 0; i < NP; i++)
      if (pend_m[i]) chk($sformatf("m_rsp_rdata%0d", i), rsp_rdata[i*DW +: DW], pdata_m[i]);
    g_q     = g;
    reset_q = reset;
    write_q = req_write;
    rrdy_q  = rsp_ready;
    for (int i = 0; i < NP; i++) begin
      addr_q[i] = req_addr[i*AW +: AW];
      strb_q[i] = req_strb[i*8 +: 8];
      wd_q[i]   = req_wdata[i*DW +: DW];
    end
  end

  always @(posedge clk) begin
    logic [NP-1:0] hs;
    hs = pend_m & rrdy_q;
    if (!reset_q) pend_m = pend_m & ~hs;
    if (g_q >= 0) begin
      if (write_q[g_q]) begin
        for (int b = 0; b < 8; b++)
          if (strb_q[g_q][b]) ref_mem[addr_q[g_q]][b*8 +: 8] = wd_q[g_q][b*8 +: 8];
      end else if (!reset_q) begin
        pend_m[g_q]  = 1'b1;
        pdata_m[g_q] = ref_mem[addr_q[g_q]];
      end
      if (!reset_q) rr_m = g_q;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    bit            pre_reset;
    logic [1:0]    valid, write, rrdy;
    logic [7:0]    a0, a1;
    logic [63:0]   wd0;
    logic [7:0]    st0;
    logic [1:0]    er, ev;
    logic [63:0]   d0, d1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rs, input logic [1:0] valid, write, rrdy,
                              input logic [7:0] a0, a1, input logic [63:0] wd0,
                              input logic [7:0] st0, input logic [1:0] er, ev,
                              input logic [63:0] d0, d1);
    vec_t v;
    v.pre_reset = rs; v.valid = valid; v.write = write; v.rrdy = rrdy;
    v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.st0 = st0;
    v.er = er; v.ev = ev; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_strb = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.pre_reset) do_reset();
    req_valid = v.valid; req_write = v.write; rsp_ready = v.rrdy;
    req_addr  = {v.a1, v.a0};
    req_wdata = {64'h0, v.wd0};
    req_strb  = {8'h00, v.st0};
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), req_ready, v.er);
    chk($sformatf("v%0d_rvalid", idx), rsp_valid, v.ev);
    if (v.ev[0]) chk($sformatf("v%0d_d0", idx), rsp_rdata[63:0], v.d0);
    if (v.ev[1]) chk($sformatf("v%0d_d1", idx), rsp_rdata[127:64], v.d1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] ones;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int a = 0; a < 256; a++) begin
      mem[a]     = 64'(a * 3);
      ref_mem[a] = 64'(a * 3);
    end
    mem[8'h05] = 64'hAA; ref_mem[8'h05] = 64'hAA;
    mem[8'h20] = ones;   ref_mem[8'h20] = ones;
    bram_rddata = '0;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single-port streaming
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b11, 8'h10, 8'h00, 64'h0, 8'h00, 2'b01, 2'b00, 64'h0, 64'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 8'h11, 8'h00, 64'h0, 8'h00, 2'b01, 2'b01, 64'h30, 64'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 8'h12, 8'h00, 64'h0, 8'h00, 2'b01, 2'b01, 64'h33, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0, 8'h00, 2'b00, 2'b01, 64'h36, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0, 8'h00, 2'b00, 2'b00, 64'h0, 64'h0));
    // round-robin fairness from reset
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b11, 8'h01, 8'h02, 64'h0, 8'h00, 2'b01, 2'b00, 64'h0, 64'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 8'h01, 8'h02, 64'h0, 8'h00, 2'b10, 2'b01, 64'h3, 64'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 8'h01, 8'h02, 64'h0, 8'h00, 2'b01, 2'b10, 64'h0, 64'h6));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 8'h01, 8'h02, 64'h0, 8'h00, 2'b10, 2'b01, 64'h3, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0, 8'h00, 2'b00, 2'b10, 64'h0, 64'h6));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0, 8'h00, 2'b00, 2'b00, 64'h0, 64'h0));
    // backpressure with concurrent write to the same address
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b01, 8'h00, 8'h05, 64'h0,  8'h00, 2'b10, 2'b00, 64'h0, 64'h0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 2'b01, 8'h05, 8'h05, 64'hBB, 8'hFF, 2'b01, 2'b10, 64'h0, 64'hAA));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b01, 8'h00, 8'h05, 64'h0,  8'h00, 2'b00, 2'b10, 64'h0, 64'hAA));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b01, 8'h00, 8'h05, 64'h0,  8'h00, 2'b00, 2'b10, 64'h0, 64'hAA));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 8'h00, 8'h05, 64'h0,  8'h00, 2'b10, 2'b10, 64'h0, 64'hAA));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0,  8'h00, 2'b00, 2'b10, 64'h0, 64'hBB));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0,  8'h00, 2'b00, 2'b00, 64'h0, 64'h0));
    // partial-strobe write then read from the other port
    tbl.push_back(mk(0, 2'b01, 2'b01, 2'b11, 8'h20, 8'h00, 64'h1234, 8'h03, 2'b01, 2'b00, 64'h0, 64'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 8'h00, 8'h20, 64'h0,    8'h00, 2'b10, 2'b00, 64'h0, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0,    8'h00, 2'b00, 2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_1234));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0,    8'h00, 2'b00, 2'b00, 64'h0, 64'h0));
    // accept and reissue in the same cycle
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 8'h06, 8'h00, 64'h0, 8'h00, 2'b01, 2'b00, 64'h0,  64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 8'h00, 2'b00, 2'b01, 64'h12, 64'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 8'h07, 8'h00, 64'h0, 8'h00, 2'b01, 2'b01, 64'h12, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 64'h0, 8'h00, 2'b00, 2'b01, 64'h15, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 64'h0, 8'h00, 2'b00, 2'b00, 64'h0,  64'h0));
    // all-zero strobe write leaves the word unchanged
    tbl.push_back(mk(0, 2'b01, 2'b01, 2'b11, 8'h10, 8'h00, 64'hFFFF, 8'h00, 2'b01, 2'b00, 64'h0,  64'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 8'h10, 8'h00, 64'h0,    8'h00, 2'b01, 2'b00, 64'h0,  64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0,    8'h00, 2'b00, 2'b01, 64'h30, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 64'h0,    8'h00, 2'b00, 2'b00, 64'h0,  64'h0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reset the cycle after a port1 read grant: response must vanish and never appear
    req_valid = 2'b10; req_write = 2'b00; rsp_ready = 2'b11; req_addr = {8'h03, 8'h00};
    @(negedge clk);
    chk("rst_pre_grant", req_ready, 2'b10);
    @(posedge clk);
    #1 reset = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("rst_rvalid_now", rsp_valid, 2'b00);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 2'b00);
      @(posedge clk);
      #1;
    end
    req_valid = 2'b11; req_addr = {8'h02, 8'h01};
    @(negedge clk);
    chk("rst_first_grant", req_ready, 2'b01);
    @(posedge clk);
    #1 idle_inputs(); rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;

    // random traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      req_valid = 2'($urandom);
      req_write = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      req_addr  = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 31))};
      req_strb  = 16'($urandom);
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    idle_inputs();
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
